// File: rtl/hub75_bcm_driver.sv
// rtl/hub75_bcm_driver.sv - HUB75 LED matrix scan driver using binary-coded modulation
// Optional global dimming of the display window is enabled by defining DISPLAY_BRIGHTNESS_EN.
module hub75_bcm_driver #(
    parameter int ROWS         = 8,
    parameter int COLUMNS      = 32,
    parameter int DEPTH        = 8,
    parameter int BASE_CYCLES  = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       en,
    input  logic [7:0]                                 brightness,
    output logic [$clog2(ROWS)-1:0]                    row,
    output logic [$clog2(COLUMNS)-1:0]                 column,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] plane,
    output logic                                       oclk,
    output logic                                       lat,
    output logic                                       oe,
    output logic                                       busy,
    output logic                                       frame_done
);

    localparam int RW      = $clog2(ROWS);
    localparam int CLW     = $clog2(COLUMNS);
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MAX_WIN = BASE_CYCLES << (DEPTH - 1);
    localparam int CW      = (MAX_WIN > 1) ? $clog2(MAX_WIN) : 1;
    localparam int BW      = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    // One counter serves both the display window and the blanking interval.
    localparam int NW      = (CW > BW) ? CW : BW;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        SHOW,
        BLANK
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CLW-1:0]  col_q, col_d;
    logic [PW-1:0]   plane_q, plane_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic            oclk_q, oclk_d;
    logic            lat_q, lat_d;
    logic            oe_q, oe_d;
    logic            busy_q, busy_d;
    logic            fd_q, fd_d;

    logic [NW:0]     win_len;
    logic            win_last;
    logic            blank_last;
    logic            col_last;
    logic            row_last;
    logic            plane_last;
    logic            show_on;

    assign win_len    = (NW+1)'(BASE_CYCLES) << plane_q;
    assign win_last   = (cnt_q == NW'(win_len - (NW+1)'(1)));
    assign blank_last = (cnt_q == NW'(BLANK_CYCLES - 1));
    assign col_last   = (col_q == CLW'(COLUMNS - 1));
    assign row_last   = (row_q == RW'(ROWS - 1));
    assign plane_last = (plane_q == PW'(DEPTH - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        plane_d = plane_q;
        cnt_d   = cnt_q;
        fd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (col_last) begin
                    col_d   = '0;
                    state_d = LATCH;
                end else begin
                    col_d   = col_q + CLW'(1);
                    state_d = SHIFT_LO;
                end
            end
            LATCH: begin
                cnt_d   = '0;
                state_d = SHOW;
            end
            SHOW: begin
                if (win_last) begin
                    cnt_d   = '0;
                    state_d = BLANK;
                end else begin
                    cnt_d = cnt_q + NW'(1);
                end
            end
            BLANK: begin
                if (blank_last) begin
                    cnt_d   = '0;
                    state_d = SHIFT_LO;
                    if (!plane_last) begin
                        plane_d = plane_q + PW'(1);
                    end else begin
                        plane_d = '0;
                        if (row_last) begin
                            row_d = '0;
                            fd_d  = 1'b1;
                            if (!en) state_d = IDLE;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + NW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef DISPLAY_BRIGHTNESS_EN
    localparam int PRW = NW + 9;

    logic [7:0] bri_q, bri_d;

    // Captured at the first shift of a frame so a frame is never displayed at mixed levels.
    always_comb begin
        bri_d = bri_q;
        if (state_q == SHIFT_LO && row_q == '0 && plane_q == '0 && col_q == '0) begin
            bri_d = brightness;
        end
    end

    assign show_on = (PRW'({cnt_d, 8'h00}) < (PRW'(win_len) * PRW'(bri_q)));

    always_ff @(posedge clk) begin
        if (rst) bri_q <= '0;
        else     bri_q <= bri_d;
    end
`else
    logic unused_brightness;

    assign show_on           = 1'b1;
    assign unused_brightness = ^brightness;
`endif

    // Outputs are decoded from the next state so that every pin comes straight from a flop.
    always_comb begin
        oclk_d = (state_d == SHIFT_HI);
        lat_d  = (state_d != LATCH);
        oe_d   = !((state_d == SHOW) && show_on);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            plane_q <= '0;
            cnt_q   <= '0;
            oclk_q  <= 1'b0;
            lat_q   <= 1'b1;
            oe_q    <= 1'b1;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            plane_q <= plane_d;
            cnt_q   <= cnt_d;
            oclk_q  <= oclk_d;
            lat_q   <= lat_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            fd_q    <= fd_d;
        end
    end

    assign row        = row_q;
    assign column     = col_q;
    assign plane      = plane_q;
    assign oclk       = oclk_q;
    assign lat        = lat_q;
    assign oe         = oe_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;

endmodule

// File: doc/hub75_bcm_driver.md
# hub75_bcm_driver

Parametrised successor to the single-display PWM driver: generates row, column and bit-plane addresses plus the panel's OE/LAT/CLK control for a HUB75-style LED matrix. It uses binary-coded modulation (BCM): each bit plane is displayed for a window proportional to its weight. This replaces a full PWM cycle counter and cuts frame time from O(2^depth) to O(depth) shift passes. It sits between the frame buffer, which is addressed by `row`/`column`/`plane`, and the panel pins.

## Interface
- `ROWS`, 8, addressable rows (≥2)
- `COLUMNS`, 32, pixels shifted per row (≥2)
- `DEPTH`, 8, bit planes per pixel (1–12)
- `BASE_CYCLES`, 4, display window of plane 0 in clk cycles (≥1)
- `BLANK_CYCLES`, 2, OE-high dead time after each window, before row/plane advance (≥1)
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  run enable
- `brightness`  in  8  global dimming (used only with DISPLAY_BRIGHTNESS_EN)
- `row`  out  $clog2(ROWS)  panel row address and frame-buffer row
- `column`  out  $clog2(COLUMNS)  frame-buffer column being shifted
- `plane`  out  $clog2(DEPTH) (min 1)  frame-buffer bit plane being shifted or displayed
- `oclk`  out  1  panel shift clock, data sampled on rising edge
- `lat`  out  1  panel latch, active low
- `oe`  out  1  panel output enable, active low
- `busy`  out  1  high whenever state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse at the end of every frame

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH, SHOW, BLANK.
- IDLE: oe=1, lat=1, oclk=0. If `en`=1, go to SHIFT_LO.
- SHIFT_LO: oclk=0, `column` valid for the frame-buffer read. Next state is SHIFT_HI.
- SHIFT_HI: oclk=1.
  - If column = COLUMNS-1: column←0, next state LATCH.
  - Otherwise: column+1, next state SHIFT_LO.
- LATCH: lat=0 for exactly one cycle, oe=1, oclk=0. Clear the window counter. Next state is SHOW.
- SHOW: window length W = BASE_CYCLES << plane cycles. Counter runs 0..W-1, then the state goes to BLANK. The oe rule is given under Configuration.
- BLANK: oe=1 for BLANK_CYCLES cycles. On the last cycle:
  - If plane < DEPTH-1: plane+1.
  - Otherwise: plane←0, and row+1 (or row←0 with frame_done=1 when row = ROWS-1).
  - Next state is SHIFT_LO. At frame end with `en`=0, next state is IDLE instead.
- Scan order: for each row, planes 0..DEPTH-1. `row` changes only in BLANK, so it never changes while oe=0.
- `en` is sampled only in IDLE and on the final BLANK cycle of a frame. Deasserting it mid-frame completes the frame first.
- Reset, including mid-operation: state IDLE, row=0, column=0, plane=0, oe=1, lat=1, oclk=0, busy=0, frame_done=0, counters 0. Every output is registered.

## Timing
- Cycles per plane b: 2·COLUMNS + 1 + (BASE_CYCLES<<b) + BLANK_CYCLES.
- Frame = ROWS · Σ over b of the per-plane count. With defaults: 8·(8·(64+1+2) + 4·255) = 12448 cycles, about 964 Hz at 12 MHz.
- From `en` high in IDLE to the first oclk rise: 2 cycles.
- The window counter is $clog2(BASE_CYCLES<<(DEPTH-1)) bits wide. It must not overflow at the maximum W.
- The frame-buffer read has a 1-cycle latency. The address is presented in SHIFT_LO and the data is on the panel pins by the SHIFT_HI edge. The data path is outside this block.

## Configuration
- `DISPLAY_BRIGHTNESS_EN` defined:
  - `brightness` is latched into an internal register on the first SHIFT_LO of each frame, so a mid-frame change has no effect until the next frame.
  - In SHOW, oe=0 only while (count<<8) < W·brightness_reg. brightness=0 keeps oe=1 for the whole frame.
  - Window length and frame timing are unchanged.
- Undefined: the `brightness` port is ignored and oe=0 for the whole SHOW window. No multiplier is synthesised.

## Test plan
- Reset/idle: rst=1 then 0 with en=0 for 20 cycles → oe=1, lat=1, oclk=0, busy=0, row=column=plane=0 throughout.
- Frame sequence: ROWS=4, COLUMNS=4, DEPTH=2, BASE=2, BLANK=1, en=1 →
  - oclk pulses 4 per plane
  - lat low for 1 cycle per plane
  - oe low for 2 then 4 cycles alternately
  - frame_done pulses every 104 cycles
  - row steps 0,1,2,3,0
- Row safety: same config, check every cycle → row and plane never change while oe=0; lat is never 0 when oe=0.
- Enable drop: deassert en mid-frame (row=1) → the frame completes, frame_done pulses, then IDLE. Re-asserting en gives the first oclk rise 2 cycles later.
- Brightness (macro on): W=4 window with brightness=128 → oe low for 2 cycles. brightness=0 → oe never low. Changing brightness mid-frame → takes effect only in the next frame.
- Reset mid-SHOW: rst asserted during oe=0 → next cycle oe=1, state IDLE, all counters 0.
